// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - control and counter-feedback bundle for countdown_ctrl
interface countdown_ctrl_if #(
  parameter int dw = 8
);
  logic          start;
  logic          pause;
  logic          abort;
  logic [dw-1:0] count_in;
  logic          cnt_reset;
  logic          cnt_ena;
  logic          busy;
  logic          paused;
  logic          done;

  modport master (
    output start, pause, abort, count_in,
    input  cnt_reset, cnt_ena, busy, paused, done
  );

  modport slave (
    input  start, pause, abort, count_in,
    output cnt_reset, cnt_ena, busy, paused, done
  );
endinterface

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - sequences one down-counter run per start with prescale, pause and abort
module countdown_ctrl #(
  parameter int dw       = 8,
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 4
) (
  input logic             clk,
  input logic             reset,
  countdown_ctrl_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  // A zero reload can never produce a decrement, so enable is tied off at build time.
  localparam bit HAS_COUNT = (WIDTH != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [dw-1:0] count_q;
  logic          cnt_zero;

  assign count_q  = bus.count_in;
  assign cnt_zero = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pre   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pre <= '0;
          if (bus.start) state <= LOAD;
        end
        LOAD: begin
          pre   <= '0;
          state <= bus.abort ? IDLE : RUN;
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
            pre   <= '0;
          end else begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
            if (cnt_zero)       state <= DONE;
            else if (bus.pause) state <= PAUSE;
          end
        end
        PAUSE: begin
          // pre is held so the decrement phase survives the pause
          if (bus.abort) begin
            state <= IDLE;
            pre   <= '0;
          end else if (!bus.pause) begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
          pre   <= '0;
        end
        default: begin
          state <= IDLE;
          pre   <= '0;
        end
      endcase
    end
  end

  assign bus.cnt_reset = (state == IDLE) || (state == LOAD) || (state == DONE);
  assign bus.cnt_ena   = HAS_COUNT && (state == RUN) && (pre == PRE_LAST) && !cnt_zero;
  assign bus.busy      = (state == LOAD) || (state == RUN) || (state == PAUSE);
  assign bus.paused    = (state == PAUSE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - randomized self-checking bench for countdown_ctrl over three parameter sets
module tb_countdown_ctrl;

  localparam int NU = 3;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;
  localparam int N_ITER  = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, pause, abort;
  logic [7:0] cnt [NU];
  logic [NU-1:0] o_rst, o_ena, o_busy, o_paused, o_done;

  int pw [NU] = '{7, 0, 7};
  int pp [NU] = '{4, 4, 1};

  for (genvar g = 0; g < NU; g++) begin : g_unit
    localparam int GW = (g == 1) ? 0 : 7;
    localparam int GP = (g == 2) ? 1 : 4;
    countdown_ctrl_if #(.dw(8)) cif ();
    assign cif.start    = start;
    assign cif.pause    = pause;
    assign cif.abort    = abort;
    assign cif.count_in = cnt[g];
    assign o_rst[g]     = cif.cnt_reset;
    assign o_ena[g]     = cif.cnt_ena;
    assign o_busy[g]    = cif.busy;
    assign o_paused[g]  = cif.paused;
    assign o_done[g]    = cif.done;
    countdown_ctrl #(.dw(8), .WIDTH(GW), .PRESCALE(GP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (cif.slave)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // reference: mode of the run, ticks = non-paused RUN cycles since entering RUN, mcount = ideal counter
  int mode [NU];
  int ticks [NU];
  int mcount [NU];
  bit tracking [NU];
  int start_it [NU], ena_n [NU], busy_n [NU], last_ena [NU], pz_total [NU], pz_since [NU];
  bit s_rst [NU], s_ena [NU], e_rst [NU], e_ena [NU];
  int pause_left;

  initial begin
    reset = 1'b1; start = 1'b1; pause = 1'b0; abort = 1'b0;
    pause_left = 0;
    for (int g = 0; g < NU; g++) begin
      cnt[g] = 8'(pw[g]);
      mode[g] = M_IDLE; ticks[g] = 0; mcount[g] = pw[g]; tracking[g] = 1'b0;
    end
    @(posedge clk); #1;

    for (int it = 0; it < N_ITER; it++) begin
      // drive this cycle's inputs
      reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
      if (it < 2) begin
        reset = 1'b1; start = 1'b1;
      end else if (it == 2 || it == 40 || it == 60 || it == 110) begin
        start = 1'b1;
      end else if (it == 52) begin
        pause = 1'b1; abort = 1'b1;
      end else if (it >= 70 && it < 75) begin
        pause = 1'b1;
      end else if (it == 125) begin
        abort = 1'b1;
      end else if (it >= 140 && it < 300) begin
        start = 1'b1;
      end else if (it >= 300) begin
        start = (((it / 250) % 3) == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
        if (pause_left > 0) begin
          pause = 1'b1; pause_left--;
        end else if ($urandom_range(0, 39) == 0) begin
          pause_left = $urandom_range(1, 6);
        end
        abort = ($urandom_range(0, 119) == 0);
        reset = ($urandom_range(0, 499) == 0);
      end

      @(negedge clk);
      for (int g = 0; g < NU; g++) begin
        e_rst[g] = (mode[g] == M_IDLE) || (mode[g] == M_LOAD) || (mode[g] == M_DONE);
        e_ena[g] = (mode[g] == M_RUN) && ((ticks[g] % pp[g]) == pp[g] - 1) && (mcount[g] != 0);
        check($sformatf("u%0d_cnt_reset it%0d", g, it), int'(o_rst[g]), int'(e_rst[g]));
        check($sformatf("u%0d_cnt_ena it%0d", g, it), int'(o_ena[g]), int'(e_ena[g]));
        check($sformatf("u%0d_busy it%0d", g, it), int'(o_busy[g]),
              int'(mode[g] == M_LOAD || mode[g] == M_RUN || mode[g] == M_PAUSE));
        check($sformatf("u%0d_paused it%0d", g, it), int'(o_paused[g]), int'(mode[g] == M_PAUSE));
        check($sformatf("u%0d_done it%0d", g, it), int'(o_done[g]), int'(mode[g] == M_DONE));
        s_rst[g] = o_rst[g];
        s_ena[g] = o_ena[g];

        if (tracking[g]) begin
          if (o_ena[g]) begin
            ena_n[g]++;
            if (last_ena[g] >= 0)
              check($sformatf("u%0d_ena_gap it%0d", g, it), it - last_ena[g], pp[g] + pz_since[g]);
            last_ena[g] = it;
            pz_since[g] = 0;
          end
          if (o_busy[g]) busy_n[g]++;
          if (mode[g] == M_PAUSE) begin
            pz_total[g]++; pz_since[g]++;
          end
          if (o_done[g]) begin
            check($sformatf("u%0d_latency it%0d", g, it), it - start_it[g], pw[g] * pp[g] + 3 + pz_total[g]);
            check($sformatf("u%0d_pulses it%0d", g, it), ena_n[g], pw[g]);
            check($sformatf("u%0d_busy_len it%0d", g, it), busy_n[g], pw[g] * pp[g] + 2 + pz_total[g]);
            tracking[g] = 1'b0;
          end
        end
      end

      @(posedge clk); #1;
      for (int g = 0; g < NU; g++) begin
        if (s_rst[g])      cnt[g] = 8'(pw[g]);
        else if (s_ena[g]) cnt[g] = cnt[g] - 8'd1;

        if (reset) begin
          mode[g] = M_IDLE; ticks[g] = 0; tracking[g] = 1'b0;
        end else begin
          case (mode[g])
            M_IDLE: if (start) begin
              mode[g] = M_LOAD;
              tracking[g] = 1'b1; start_it[g] = it;
              ena_n[g] = 0; busy_n[g] = 0; last_ena[g] = -1; pz_total[g] = 0; pz_since[g] = 0;
            end
            M_LOAD: begin
              ticks[g] = 0;
              if (abort) begin
                mode[g] = M_IDLE; tracking[g] = 1'b0;
              end else begin
                mode[g] = M_RUN;
              end
            end
            M_RUN: if (abort) begin
              mode[g] = M_IDLE; tracking[g] = 1'b0;
            end else begin
              ticks[g]++;
              if (mcount[g] == 0) mode[g] = M_DONE;
              else if (pause)     mode[g] = M_PAUSE;
            end
            M_PAUSE: if (abort) begin
              mode[g] = M_IDLE; tracking[g] = 1'b0;
            end else if (!pause) begin
              mode[g] = M_RUN;
            end
            default: mode[g] = M_IDLE;
          endcase
        end

        if (e_rst[g])      mcount[g] = pw[g];
        else if (e_ena[g]) mcount[g] = mcount[g] - 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller directly upstream of the lab-1 down counter. Drives the counter's `reset` and `ena` inputs to run one countdown from `WIDTH` to 0 per `start` request, with a programmable prescaler setting the decrement rate. Watches the counter's `result` (fed back as `count_in`), supports pause/resume and abort, and pulses `done` when the count reaches zero.

## Interface

- `dw`, 8, width of the counter value bus.
- `WIDTH`, 7, reload value the counter loads on reset; must satisfy `WIDTH < 2**dw`.
- `PRESCALE`, 4, clock cycles per decrement; must be ≥ 1. Prescaler register width is `max(1, $clog2(PRESCALE))`.

Ports:

- `clk`  in  1  single clock; all state updates on the posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; requests a countdown; sampled only in IDLE.
- `pause`  in  1  level; while high in RUN/PAUSE, decrements are suspended.
- `abort`  in  1  level; cancels a countdown in LOAD/RUN/PAUSE.
- `count_in`  in  dw  counter `result` fed back.
- `cnt_reset`  out  1  drives counter `reset`.
- `cnt_ena`  out  1  drives counter `ena`.
- `busy`  out  1  high in LOAD, RUN, PAUSE.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  one-cycle completion pulse, high in DONE.

## Operation

- **States:** IDLE, LOAD, RUN, PAUSE, DONE. Prescaler register `pre`.
- **Reset:**
  - state IDLE, `pre`=0.
  - Outputs: `cnt_reset`=1, `cnt_ena`=0, `busy`=0, `paused`=0, `done`=0.
- **Output decode:** combinational from registered state, `pre` and `count_in` only. `pause`, `abort` and `start` affect outputs from the next cycle.
  - `cnt_reset` = state ∈ {IDLE, LOAD, DONE}.
  - `cnt_ena` = (state==RUN) && (`pre`==PRESCALE-1) && (`count_in`!=0).
  - `cnt_reset` and `cnt_ena` are never high together.
- **Input priority:** abort > pause > start.
- **IDLE:**
  - `start` → LOAD.
  - Otherwise stay in IDLE; `pre` held at 0.
- **LOAD:**
  - Lasts one cycle; `cnt_reset` reloads the counter to `WIDTH` at the edge leaving LOAD.
  - `abort` → IDLE; otherwise → RUN with `pre`=0.
- **RUN:**
  - `abort` → IDLE, `pre`=0.
  - Else `count_in`==0 → DONE.
  - Else `pause` → PAUSE.
  - Else stay in RUN.
  - In every non-abort RUN cycle, `pre` advances: it wraps from PRESCALE-1 to 0, otherwise increments.
- **PAUSE:**
  - `pre` holds; `cnt_ena`=0.
  - `abort` → IDLE, `pre`=0.
  - Else `pause` low → RUN, resuming from the held `pre`.
- **DONE:**
  - Lasts one cycle, then → IDLE with `pre`=0.
  - `start`, `pause` and `abort` are ignored.
  - A `start` held high is seen again in IDLE on the following cycle, giving back-to-back runs.
- **Reset mid-operation:** reset wins over all inputs and returns to the reset state from any state. The counter is re-held at `WIDTH` through `cnt_reset`.
- **`WIDTH`=0:** the first RUN cycle sees `count_in`==0, so the FSM goes directly to DONE and never asserts `cnt_ena`.

## Timing

- Let E0 be the edge that enters RUN. `start` sampled at edge Ts makes E0 = Ts+2 (one LOAD cycle in between).
- `cnt_ena` is high in the cycles following E0 + k·PRESCALE + (PRESCALE-1), for k = 0..WIDTH-1, when there is no pause.
- Counter reaches 0 at edge E0 + WIDTH·PRESCALE. RUN sees zero that cycle and enters DONE at the next edge.
- `done` is high in the cycle after edge E0 + WIDTH·PRESCALE + 1; IDLE follows at the next edge.
- Start-to-done latency is WIDTH·PRESCALE + 3 edges.
- Each PAUSE cycle adds exactly one cycle of latency. The phase of `pre` is preserved across a pause.
- With `PRESCALE`=1, `cnt_ena` is high every RUN cycle while `count_in`!=0.

## Test plan

All scenarios use the defaults dw=8, WIDTH=7, PRESCALE=4.

- **Reset:** hold `reset` 2 cycles with `start`=1 → `cnt_reset`=1, `busy`=0, `done`=0. After release, LOAD follows next cycle.
- **Plain run:** one-cycle `start` → exactly 7 `cnt_ena` pulses, 4 cycles apart. Counter steps 7→0. `done` is high exactly once, 31 cycles after the `start` edge. `busy` is high 30 cycles.
- **Pause:** `pause` high for 5 cycles mid-RUN → `paused` high 5 cycles, no `cnt_ena` during them, `done` delayed by exactly 5 cycles, 7 pulses total.
- **Abort:** `abort` during RUN at count 4 → IDLE next edge, `cnt_reset`=1, counter back to 7, `done` never asserted.
- **Simultaneous inputs:** `pause` and `abort` asserted together in RUN → IDLE, not PAUSE. `start` held high continuously → back-to-back runs with one IDLE cycle between `done` and the next LOAD.
- **Parameter corners:** WIDTH=0 → `done` 3 cycles after `start`, zero `cnt_ena` pulses. PRESCALE=1 → 7 consecutive `cnt_ena` cycles.
